// File: rtl/i2c_csr_pkg.sv
// Shared constants for the I2C CSR/FIFO stage: register offsets, STATUS layout,
// command word fields and the PRESCALE reset default.
package i2c_csr_pkg;

  typedef enum logic [2:0] {
    REG_PRESCALE = 3'd0,
    REG_CONTROL  = 3'd1,
    REG_STATUS   = 3'd2,
    REG_TXDATA   = 3'd3,
    REG_RXDATA   = 3'd4
  } reg_off_e;

  localparam int ST_BUSY     = 0;
  localparam int ST_TX_FULL  = 1;
  localparam int ST_TX_EMPTY = 2;
  localparam int ST_RX_FULL  = 3;
  localparam int ST_RX_EMPTY = 4;
  localparam int ST_STICKY   = 5;   // arb_lost, nack, tx_ovf, rx_ovf in [8:5]
  localparam int ST_TX_COUNT = 16;
  localparam int ST_RX_COUNT = 24;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_IRQ_EN = 1;

  localparam int CMD_START = 8;
  localparam int CMD_STOP  = 9;
  localparam int CMD_READ  = 10;
  localparam int CMD_ACK   = 11;
  localparam int CMD_W     = 12;

  localparam logic [15:0] PRESCALE_RST_DFLT = 16'h0063;

endpackage

// File: rtl/i2c_sync_fifo.sv
// Single-clock FIFO with first-word fall-through head; a push while full is
// dropped even when a pop happens in the same cycle.
module i2c_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok_s, pop_ok_s;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == {CW{1'b0}});
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;
  assign rdata     = empty ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];
  assign count     = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/i2c_csr_fifo.sv
// I2C master CSR block: BRAM-style register port, TX command FIFO towards the
// byte controller, RX data FIFO from it, sticky status and a level interrupt.
module i2c_csr_fifo
  import i2c_csr_pkg::*;
#(
  parameter int          DEPTH        = 4,
  parameter logic [15:0] PRESCALE_RST = PRESCALE_RST_DFLT
) (
  input  logic              s_axi_aclk,
  input  logic              s_axi_areset,
  input  logic [31:0]       bram_addr,
  input  logic [31:0]       bram_wr_data,
  output logic [31:0]       bram_rd_data,
  input  logic              bram_en,
  input  logic              bram_we,
  input  logic              bram_re,
  output logic [15:0]       prescale,
  output logic              core_en,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [CMD_W-1:0]  cmd_data,
  input  logic              rsp_valid,
  input  logic [7:0]        rsp_data,
  input  logic              core_busy,
  input  logic              core_arb_lost,
  input  logic              core_nack,
  output logic              irq
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [15:0]      prescale_q, prescale_d;
  logic             enable_q, enable_d;
  logic             irq_en_q, irq_en_d;
  logic [3:0]       sticky_q, sticky_d;
  logic [31:0]      rd_data_q, rd_data_d;
  logic             irq_q, irq_d;

  logic [2:0]       addr_s;
  logic             wr_s, rd_s;
  logic             tx_push_s, tx_pop_s, tx_full_s, tx_empty_s;
  logic [CW-1:0]    tx_count_s;
  logic [CMD_W-1:0] tx_head_s;
  logic             rx_pop_s, rx_full_s, rx_empty_s;
  logic [CW-1:0]    rx_count_s;
  logic [7:0]       rx_head_s;
  logic [3:0]       sticky_set_s, sticky_clr_s;
  logic [31:0]      status_s, rd_mux_s;
  logic             unused_bits_s;

  assign addr_s    = bram_addr[4:2];
  assign wr_s      = bram_en & bram_we;
  assign rd_s      = bram_en & bram_re & ~bram_we;
  assign tx_push_s = wr_s & (addr_s == REG_TXDATA);
  assign tx_pop_s  = cmd_valid & cmd_ready;
  assign rx_pop_s  = rd_s & (addr_s == REG_RXDATA);

  assign unused_bits_s = ^{bram_addr[31:5], bram_addr[1:0], bram_wr_data[31:16]};

  i2c_sync_fifo #(.WIDTH(CMD_W), .DEPTH(DEPTH)) u_tx_fifo (
    .clk   (s_axi_aclk),
    .rst   (s_axi_areset),
    .push  (tx_push_s),
    .pop   (tx_pop_s),
    .wdata (bram_wr_data[CMD_W-1:0]),
    .rdata (tx_head_s),
    .full  (tx_full_s),
    .empty (tx_empty_s),
    .count (tx_count_s)
  );

  i2c_sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
    .clk   (s_axi_aclk),
    .rst   (s_axi_areset),
    .push  (rsp_valid),
    .pop   (rx_pop_s),
    .wdata (rsp_data),
    .rdata (rx_head_s),
    .full  (rx_full_s),
    .empty (rx_empty_s),
    .count (rx_count_s)
  );

  always_comb begin
    status_s                    = 32'd0;
    status_s[ST_BUSY]           = core_busy;
    status_s[ST_TX_FULL]        = tx_full_s;
    status_s[ST_TX_EMPTY]       = tx_empty_s;
    status_s[ST_RX_FULL]        = rx_full_s;
    status_s[ST_RX_EMPTY]       = rx_empty_s;
    status_s[ST_STICKY +: 4]    = sticky_q;
    status_s[ST_TX_COUNT +: CW] = tx_count_s;
    status_s[ST_RX_COUNT +: CW] = rx_count_s;
    case (addr_s)
      REG_PRESCALE: rd_mux_s = {16'd0, prescale_q};
      REG_CONTROL:  rd_mux_s = {30'd0, irq_en_q, enable_q};
      REG_STATUS:   rd_mux_s = status_s;
      REG_RXDATA:   rd_mux_s = {23'd0, ~rx_empty_s, rx_head_s};
      default:      rd_mux_s = 32'd0;
    endcase
  end

  always_comb begin
    prescale_d = prescale_q;
    enable_d   = enable_q;
    irq_en_d   = irq_en_q;
    if (wr_s) begin
      case (addr_s)
        REG_PRESCALE: prescale_d = bram_wr_data[15:0];
        REG_CONTROL: begin
          enable_d = bram_wr_data[CTRL_ENABLE];
          irq_en_d = bram_wr_data[CTRL_IRQ_EN];
        end
        default: prescale_d = prescale_q;
      endcase
    end else begin
      prescale_d = prescale_q;
    end

    if (wr_s && (addr_s == REG_STATUS)) begin
      sticky_clr_s = bram_wr_data[ST_STICKY +: 4];
    end else begin
      sticky_clr_s = 4'd0;
    end
    // New events are OR-ed in after the W1C mask so a same-cycle set wins.
    sticky_set_s = {rsp_valid & rx_full_s, tx_push_s & tx_full_s, core_nack, core_arb_lost};
    sticky_d     = (sticky_q & ~sticky_clr_s) | sticky_set_s;

    if (rd_s) begin
      rd_data_d = rd_mux_s;
    end else begin
      rd_data_d = rd_data_q;
    end

    irq_d = irq_en_q & ((|sticky_q) | ~rx_empty_s | (tx_empty_s & ~core_busy));
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      prescale_q <= PRESCALE_RST;
      enable_q   <= 1'b0;
      irq_en_q   <= 1'b0;
      sticky_q   <= 4'd0;
      rd_data_q  <= 32'd0;
      irq_q      <= 1'b0;
    end else begin
      prescale_q <= prescale_d;
      enable_q   <= enable_d;
      irq_en_q   <= irq_en_d;
      sticky_q   <= sticky_d;
      rd_data_q  <= rd_data_d;
      irq_q      <= irq_d;
    end
  end

  assign bram_rd_data = rd_data_q;
  assign prescale     = prescale_q;
  assign core_en      = enable_q;
  assign irq          = irq_q;
  assign cmd_valid    = ~tx_empty_s & enable_q;
  assign cmd_data     = tx_head_s;

endmodule

// File: tb/tb_i2c_csr_fifo.sv
// Directed self-checking bench for i2c_csr_fifo (DEPTH=4).
module tb_i2c_csr_fifo;

  logic        clk = 1'b0;
  logic        s_axi_areset;
  logic [31:0] bram_addr, bram_wr_data, bram_rd_data;
  logic        bram_en, bram_we, bram_re;
  logic [15:0] prescale;
  logic        core_en, cmd_valid, cmd_ready;
  logic [11:0] cmd_data;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        core_busy, core_arb_lost, core_nack, irq;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  i2c_csr_fifo #(.DEPTH(4), .PRESCALE_RST(16'h0063)) dut (
    .s_axi_aclk    (clk),
    .s_axi_areset  (s_axi_areset),
    .bram_addr     (bram_addr),
    .bram_wr_data  (bram_wr_data),
    .bram_rd_data  (bram_rd_data),
    .bram_en       (bram_en),
    .bram_we       (bram_we),
    .bram_re       (bram_re),
    .prescale      (prescale),
    .core_en       (core_en),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_data      (cmd_data),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .core_busy     (core_busy),
    .core_arb_lost (core_arb_lost),
    .core_nack     (core_nack),
    .irq           (irq)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] off, input logic [31:0] data);
    @(negedge clk);
    bram_addr    = {27'd0, off, 2'b00};
    bram_wr_data = data;
    bram_en      = 1'b1;
    bram_we      = 1'b1;
    @(negedge clk);
    bram_en = 1'b0;
    bram_we = 1'b0;
  endtask

  task automatic read_check(input logic [2:0] off, input logic [31:0] exp, input string tag);
    @(negedge clk);
    bram_addr = {27'd0, off, 2'b00};
    bram_en   = 1'b1;
    bram_re   = 1'b1;
    @(negedge clk);
    bram_en = 1'b0;
    bram_re = 1'b0;
    check_eq(tag, bram_rd_data, exp);
  endtask

  task automatic rx_byte(input logic [7:0] b);
    @(negedge clk);
    rsp_valid = 1'b1;
    rsp_data  = b;
    @(negedge clk);
    rsp_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_reset [8];
    exp_reset = '{32'h0000_0063, 32'd0, 32'h0000_0014, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};

    s_axi_areset  = 1'b1;
    bram_addr     = 32'd0;
    bram_wr_data  = 32'd0;
    bram_en       = 1'b0;
    bram_we       = 1'b0;
    bram_re       = 1'b0;
    cmd_ready     = 1'b0;
    rsp_valid     = 1'b0;
    rsp_data      = 8'd0;
    core_busy     = 1'b0;
    core_arb_lost = 1'b0;
    core_nack     = 1'b0;
    repeat (3) @(negedge clk);
    s_axi_areset = 1'b0;

    // Reset state and full register map sweep
    check_eq("rst_prescale", {16'd0, prescale}, 32'h0000_0063);
    check_eq("rst_core_en", {31'd0, core_en}, 32'd0);
    check_eq("rst_irq", {31'd0, irq}, 32'd0);
    check_eq("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    check_eq("rst_rd_data", bram_rd_data, 32'd0);
    for (int i = 0; i < 8; i++) begin
      read_check(3'(i), exp_reset[i], $sformatf("rst_rd_off%0d", i));
    end

    // PRESCALE write, upper bits ignored
    bus_write(3'd0, 32'h1234_ABCD);
    check_eq("prescale_out", {16'd0, prescale}, 32'h0000_ABCD);
    read_check(3'd0, 32'h0000_ABCD, "prescale_rd");

    // Single command, then one-cycle handshake
    bus_write(3'd1, 32'h0000_0001);
    check_eq("core_en_set", {31'd0, core_en}, 32'd1);
    bus_write(3'd3, 32'h0000_01A5);
    check_eq("cmd_valid_one", {31'd0, cmd_valid}, 32'd1);
    check_eq("cmd_data_one", {20'd0, cmd_data}, 32'h0000_01A5);
    read_check(3'd3, 32'd0, "txdata_rd_zero");
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    check_eq("cmd_valid_drop", {31'd0, cmd_valid}, 32'd0);
    check_eq("cmd_data_empty", {20'd0, cmd_data}, 32'd0);

    // TX overflow: 5 pushes into DEPTH=4
    for (int i = 0; i < 5; i++) begin
      bus_write(3'd3, 32'h0000_0101 + 32'(i));
    end
    read_check(3'd2, 32'h0004_0092, "tx_full_status");
    cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("tx_drain_valid%0d", i), {31'd0, cmd_valid}, 32'd1);
      check_eq($sformatf("tx_drain_data%0d", i), {20'd0, cmd_data}, 32'h0000_0101 + 32'(i));
      @(negedge clk);
    end
    cmd_ready = 1'b0;
    check_eq("tx_drained_valid", {31'd0, cmd_valid}, 32'd0);
    check_eq("tx_drained_data", {20'd0, cmd_data}, 32'd0);
    bus_write(3'd2, 32'h0000_0080);
    read_check(3'd2, 32'h0000_0014, "tx_ovf_cleared");

    // RX path: two bytes then an empty pop
    rx_byte(8'h3C);
    rx_byte(8'h7E);
    read_check(3'd4, 32'h0000_013C, "rx_pop1");
    read_check(3'd4, 32'h0000_017E, "rx_pop2");
    read_check(3'd2, 32'h0000_0014, "rx_empty_status");
    read_check(3'd4, 32'h0000_0000, "rx_pop_empty");

    // RX overflow
    for (int i = 0; i < 5; i++) begin
      rx_byte(8'h10 + 8'(i));
    end
    read_check(3'd2, 32'h0400_010C, "rx_full_status");
    for (int i = 0; i < 4; i++) begin
      read_check(3'd4, 32'h0000_0110 + 32'(i), $sformatf("rx_ovf_pop%0d", i));
    end
    bus_write(3'd2, 32'h0000_0100);
    read_check(3'd2, 32'h0000_0014, "rx_ovf_cleared");

    // Sticky nack: set beats same-cycle W1C, later W1C clears, irq follows
    core_busy = 1'b1;
    bus_write(3'd1, 32'h0000_0003);
    @(negedge clk);
    bram_addr    = {27'd0, 3'd2, 2'b00};
    bram_wr_data = 32'h0000_0040;
    bram_en      = 1'b1;
    bram_we      = 1'b1;
    core_nack    = 1'b1;
    @(negedge clk);
    bram_en   = 1'b0;
    bram_we   = 1'b0;
    core_nack = 1'b0;
    read_check(3'd2, 32'h0000_0055, "nack_set_wins");
    check_eq("irq_nack", {31'd0, irq}, 32'd1);
    bus_write(3'd2, 32'h0000_0040);
    @(negedge clk);
    check_eq("irq_cleared", {31'd0, irq}, 32'd0);
    read_check(3'd2, 32'h0000_0015, "nack_cleared");

    // Arbitration-lost sticky
    @(negedge clk);
    core_arb_lost = 1'b1;
    @(negedge clk);
    core_arb_lost = 1'b0;
    read_check(3'd2, 32'h0000_0035, "arb_set");
    check_eq("irq_arb", {31'd0, irq}, 32'd1);
    bus_write(3'd2, 32'h0000_0020);
    read_check(3'd2, 32'h0000_0015, "arb_cleared");

    // Idle core with empty TX raises irq
    core_busy = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("irq_idle", {31'd0, irq}, 32'd1);

    // Enable gates cmd issue; reset mid-operation empties FIFO
    bus_write(3'd1, 32'h0000_0002);
    for (int i = 0; i < 3; i++) begin
      bus_write(3'd3, 32'h0000_0201 + 32'(i));
    end
    check_eq("frozen_valid", {31'd0, cmd_valid}, 32'd0);
    check_eq("frozen_head", {20'd0, cmd_data}, 32'h0000_0201);
    read_check(3'd2, 32'h0003_0010, "three_pending");
    bus_write(3'd1, 32'h0000_0001);
    check_eq("unfrozen_valid", {31'd0, cmd_valid}, 32'd1);
    @(negedge clk);
    s_axi_areset = 1'b1;
    @(negedge clk);
    check_eq("midrst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    check_eq("midrst_prescale", {16'd0, prescale}, 32'h0000_0063);
    check_eq("midrst_core_en", {31'd0, core_en}, 32'd0);
    check_eq("midrst_irq", {31'd0, irq}, 32'd0);
    s_axi_areset = 1'b0;
    read_check(3'd2, 32'h0000_0014, "midrst_status");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
